// File: rtl/simd_lane_sequencer.sv
// Execute-stage sequencer: splits a vector op into LANE_BITS slices, issues them to a
// combinational ALU one lane per cycle (lane 0 first), reassembles result and merged flags.
// Latency LANES cycles from accept to OutValid; result/flags held in DONE until OutReady.
// Optional macro SIMD_LANE_SEQ_BACK_TO_BACK_EN: accept the next op in DONE when OutReady is high.
module simd_lane_sequencer #(
  parameter int LANE_BITS = 64,
  parameter int LANES     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [LANES*LANE_BITS-1:0] VecA,
  input  logic [LANES*LANE_BITS-1:0] VecB,
  input  logic [1:0]                 OpIn,
  output logic [LANE_BITS-1:0]       AluSrcA,
  output logic [LANE_BITS-1:0]       AluSrcB,
  output logic [1:0]                 AluControl,
  input  logic [LANE_BITS-1:0]       AluResult,
  input  logic [3:0]                 AluFlags,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [LANES*LANE_BITS-1:0] VecResult,
  output logic [3:0]                 VecFlags,
  output logic                       Busy
);

  localparam int VW = LANES * LANE_BITS;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [VW-1:0]        op_a_q, op_a_d;
  logic [VW-1:0]        op_b_q, op_b_d;
  logic [VW-1:0]        result_q, result_d;
  logic [1:0]           op_q, op_d;
  logic [3:0]           flags_q, flags_d;
  logic                 in_ready;
  logic [LANE_BITS-1:0] lane_a, lane_b;

  // Select the operand slices for the lane currently being issued.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_q == CW'(i)) begin
        lane_a = op_a_q[i*LANE_BITS +: LANE_BITS];
        lane_b = op_b_q[i*LANE_BITS +: LANE_BITS];
      end
    end
  end

  // Next-state logic: lane issue, result/flag collection, and operation capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    in_ready = (state_q == IDLE);
`ifdef SIMD_LANE_SEQ_BACK_TO_BACK_EN
    // Completing the output handshake frees the registers in the same edge.
    if (state_q == DONE) in_ready = OutReady;
`endif
    case (state_q)
      IDLE: ;
      ISSUE: begin
        for (int i = 0; i < LANES; i++) begin
          if (cnt_q == CW'(i)) result_d[i*LANE_BITS +: LANE_BITS] = AluResult;
        end
        flags_d[3] = flags_q[3] | AluFlags[3];
        flags_d[2] = flags_q[2] | AluFlags[2];
        // N tracks the most recent lane, so the MSB lane wins.
        flags_d[1] = AluFlags[1];
        // Z starts from lane 0 directly since the flag register is cleared on capture.
        flags_d[0] = (cnt_q == '0) ? AluFlags[0] : (flags_q[0] & AluFlags[0]);
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Capture overrides the DONE->IDLE move when back-to-back acceptance occurs.
    if (InValid && in_ready) begin
      op_a_d   = VecA;
      op_b_d   = VecB;
      op_d     = OpIn;
      result_d = '0;
      flags_d  = '0;
      cnt_d    = '0;
      state_d  = ISSUE;
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign InReady    = in_ready;
  assign AluSrcA    = (state_q == ISSUE) ? lane_a : '0;
  assign AluSrcB    = (state_q == ISSUE) ? lane_b : '0;
  assign AluControl = op_q;
  assign OutValid   = (state_q == DONE);
  assign VecResult  = result_q;
  assign VecFlags   = flags_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_simd_lane_sequencer.sv
// Bench for simd_lane_sequencer with a behavioural 64-bit ALU attached.
// Table vectors feed a scoreboard; output handshakes are popped and compared.
// Hand sequences cover backpressure, mid-operation reset and back-to-back throughput.
module tb_simd_lane_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [127:0] VecA = '0;
  logic [127:0] VecB = '0;
  logic [1:0]   OpIn = '0;
  logic [63:0]  AluSrcA, AluSrcB;
  logic [1:0]   AluControl;
  logic [63:0]  AluResult;
  logic [3:0]   AluFlags;
  logic         OutValid;
  logic         OutReady = 1'b1;
  logic [127:0] VecResult;
  logic [3:0]   VecFlags;
  logic         Busy;

`ifdef SIMD_LANE_SEQ_BACK_TO_BACK_EN
  localparam int PERIOD = 3;
  localparam int BP_GAP = 0;
`else
  localparam int PERIOD = 4;
  localparam int BP_GAP = 1;
`endif

  simd_lane_sequencer #(.LANE_BITS(64), .LANES(2)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .VecA(VecA), .VecB(VecB), .OpIn(OpIn),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluControl(AluControl),
    .AluResult(AluResult), .AluFlags(AluFlags),
    .OutValid(OutValid), .OutReady(OutReady),
    .VecResult(VecResult), .VecFlags(VecFlags), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {V,C,N,Z}; sub C means no borrow.
  function automatic logic [67:0] alu(input logic [63:0] a, input logic [63:0] b,
                                      input logic [1:0] op);
    logic [64:0] s;
    logic [63:0] r;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; r = s[63:0]; c = s[64];
                   v = (a[63] == b[63]) && (r[63] != a[63]); end
      2'b01: begin s = {1'b0, a} + {1'b0, ~b} + 65'd1; r = s[63:0]; c = s[64];
                   v = (a[63] != b[63]) && (r[63] != a[63]); end
      2'b10: r = a * b;
      default: r = a ^ b;
    endcase
    return {v, c, r[63], (r == 64'd0), r};
  endfunction

  always_comb {AluFlags, AluResult} = alu(AluSrcA, AluSrcB, AluControl);

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [1:0]   op;
    logic [127:0] res;
    logic [3:0]   flg;
  } vec_t;

  typedef struct {
    logic [127:0] res;
    logic [3:0]   flg;
  } exp_t;

  vec_t tv[5];
  exp_t sb[$];
  int   hs_q[$];
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;
  int   acc_edge = 0;
  int   last_hs_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && OutValid && OutReady) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("vec_result", VecResult, e.res);
        chk("vec_flags", {124'd0, VecFlags}, {124'd0, e.flg});
      end
      last_hs_edge = cyc + 1;
      hs_q.push_back(cyc + 1);
    end
  end

  // Present table entry idx until accepted; returns one time unit after the accept edge.
  task automatic drive_op(input int idx, input bit keep);
    int n;
    InValid = 1'b1;
    VecA = tv[idx].a;
    VecB = tv[idx].b;
    OpIn = tv[idx].op;
    n = 0;
    @(negedge clk);
    while (!InReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {127'd0, InReady}, 128'd1);
    acc_edge = cyc + 1;
    sb.push_back('{res: tv[idx].res, flg: tv[idx].flg});
    @(posedge clk);
    #1;
    if (!keep) begin
      InValid = 1'b0;
      VecA = {$urandom, $urandom, $urandom, $urandom};
      VecB = {$urandom, $urandom, $urandom, $urandom};
      OpIn = 2'($urandom);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(sb.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    tv[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 128'hFFFFFFFF_FFFFFFFF_00000000_00000000,
              2'b11, 128'hFFEEDDCC_BBAA9988_8899AABB_CCDDEEFF, 4'b0010};
    tv[1] = '{128'h1234, 128'h1234, 2'b01, 128'd0, 4'b0101};
    tv[2] = '{{64'd5, 64'hFFFF_FFFF_FFFF_FFFF}, {64'd6, 64'd1}, 2'b00,
              {64'hB, 64'h0}, 4'b0100};
    tv[3] = '{{64'h1_0000_0000, 64'd3}, {64'h1_0000_0000, 64'd7}, 2'b10,
              {64'd0, 64'd21}, 4'b0000};
    tv[4] = '{{64'h8000_0000_0000_0000, 64'd1}, {64'd1, 64'd2}, 2'b01,
              {64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 4'b1100};

    // Reset state.
    #23;
    chk("rst_outvalid", {127'd0, OutValid}, 128'd0);
    chk("rst_inready", {127'd0, InReady}, 128'd1);
    chk("rst_busy", {127'd0, Busy}, 128'd0);
    chk("rst_vecresult", VecResult, 128'd0);
    chk("rst_vecflags", {124'd0, VecFlags}, 128'd0);
    chk("rst_alusrca", {64'd0, AluSrcA}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, one at a time with OutReady high.
    for (int i = 0; i < 5; i++) begin
      drive_op(i, 1'b0);
      @(negedge clk);
      chk("lane0_src_a", {64'd0, AluSrcA}, {64'd0, tv[i].a[63:0]});
      chk("lane0_src_b", {64'd0, AluSrcB}, {64'd0, tv[i].b[63:0]});
      chk("lane0_ctrl", {126'd0, AluControl}, {126'd0, tv[i].op});
      chk("issue_inready", {127'd0, InReady}, 128'd0);
      @(negedge clk);
      chk("lane1_src_a", {64'd0, AluSrcA}, {64'd0, tv[i].a[127:64]});
      chk("lane1_src_b", {64'd0, AluSrcB}, {64'd0, tv[i].b[127:64]});
      n = 0;
      @(negedge clk);
      while (!OutValid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("latency", 128'(cyc - acc_edge), 128'd2);
      wait_drain("table_drain");
      chk("idle_busy", {127'd0, Busy}, 128'd0);
    end

    // Backpressure: result held, new op refused until the output handshake.
    OutReady = 1'b0;
    drive_op(2, 1'b0);
    n = 0;
    @(negedge clk);
    while (!OutValid && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    InValid = 1'b1;
    VecA = tv[3].a;
    VecB = tv[3].b;
    OpIn = tv[3].op;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_outvalid", {127'd0, OutValid}, 128'd1);
      chk("bp_inready", {127'd0, InReady}, 128'd0);
      chk("bp_result", VecResult, tv[2].res);
      chk("bp_flags", {124'd0, VecFlags}, {124'd0, tv[2].flg});
    end
    @(posedge clk);
    #1;
    OutReady = 1'b1;
    drive_op(3, 1'b0);
    chk("bp_accept_gap", 128'(acc_edge - last_hs_edge), 128'(BP_GAP));
    wait_drain("bp_drain");

    // Asynchronous reset after lane 0 has been issued.
    drive_op(0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_outvalid", {127'd0, OutValid}, 128'd0);
    chk("abort_inready", {127'd0, InReady}, 128'd1);
    chk("abort_result", VecResult, 128'd0);
    chk("abort_busy", {127'd0, Busy}, 128'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (OutValid) seen++;
    end
    chk("abort_no_outvalid", 128'(seen), 128'd0);
    @(posedge clk);
    #1;
    drive_op(1, 1'b0);
    wait_drain("post_abort_drain");

    // Continuous stream: four ops, results in issue order at a fixed period.
    hs_q.delete();
    for (int i = 0; i < 4; i++) drive_op(i + 1, i < 3);
    wait_drain("stream_drain");
    chk("stream_count", 128'(hs_q.size()), 128'd4);
    for (int k = 1; k < hs_q.size(); k++)
      chk("stream_period", 128'(hs_q[k] - hs_q[k-1]), 128'(PERIOD));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
